// File: rtl/branch_predictor_pkg.sv
// Shared types and helpers for the dynamic branch predictor.
package rv32i_types;

  // Widest tag the BTB entry can carry (IDX_W >= 2 and IDX_W+2+TAG_W <= 32).
  localparam int BP_TAG_MAX = 28;

  typedef struct packed {
    logic                  valid;
    logic                  jmp;
    logic [BP_TAG_MAX-1:0] tag;
    logic [31:0]           tgt;
  } bp_btb_entry_t;

  // Weakly-not-taken value for a counter of width w.
  function automatic logic [3:0] bp_ctr_init(input int w);
    return 4'((1 << (w - 1)) - 1);
  endfunction

  // Reset value for the default 2-bit counter.
  localparam logic [3:0] CTR_INIT = bp_ctr_init(2);

  // Saturating up/down step of a counter of width w (w <= 4).
  function automatic logic [3:0] bp_ctr_next(input logic [3:0] ctr, input logic taken,
                                             input int w);
    logic [3:0] max;
    max = 4'((1 << w) - 1);
    if (taken) return (ctr == max) ? ctr : ctr + 4'd1;
    return (ctr == 4'd0) ? ctr : ctr - 4'd1;
  endfunction

endpackage

// File: rtl/branch_predictor_btb.sv
// Tagged branch target buffer: flop array, async clear, 1 comb read, 1 sync write.
module bp_btb
  import rv32i_types::*;
#(
  parameter int ENTRIES = 64,
  parameter int IDX_W   = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx_i,
  output bp_btb_entry_t    rd_o,
  input  logic             we_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  bp_btb_entry_t    wr_i
);

  bp_btb_entry_t mem_q [ENTRIES];

  // Entry storage; a write overwrites whatever branch aliased into the slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[wr_idx_i] <= wr_i;
    end
  end

  // No write bypass: a same-cycle lookup sees the old entry.
  assign rd_o = mem_q[rd_idx_i];

endmodule

// File: rtl/branch_predictor.sv
// Bimodal / gshare branch predictor with tagged BTB and performance counters.
module branch_predictor
  import rv32i_types::*;
#(
  parameter int ENTRIES = 64,
  parameter int CTR_W   = 2,
  parameter int GHR_W   = 0,
  parameter int TAG_W   = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fetch_pc,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_is_br,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_mispred,
  output logic [31:0] cnt_br,
  output logic [31:0] cnt_mispred
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int GW    = (GHR_W > 0) ? GHR_W : 1;
  localparam logic [CTR_W-1:0] CTR_RST = CTR_W'(bp_ctr_init(CTR_W));

  logic [CTR_W-1:0] bht_q [ENTRIES];
  logic [GW-1:0]    ghr_q, ghr_d;
  logic [31:0]      cnt_br_q, cnt_mis_q;

  logic [IDX_W-1:0] f_bidx, f_hidx, u_bidx, u_hidx;
  logic [TAG_W-1:0] f_tag, u_tag;
  bp_btb_entry_t    rd, wr;
  logic             unused_bits;

  assign f_bidx = fetch_pc[IDX_W+1:2];
  assign u_bidx = upd_pc[IDX_W+1:2];
  assign f_tag  = fetch_pc[IDX_W+1+TAG_W:IDX_W+2];
  assign u_tag  = upd_pc[IDX_W+1+TAG_W:IDX_W+2];

  // PC high bits / low bits (and the history in bimodal mode) feed nothing.
  assign unused_bits = ^{fetch_pc, upd_pc, ghr_q};

  generate
    if (GHR_W > 0) begin : g_gshare
      assign f_hidx = f_bidx ^ IDX_W'(ghr_q);
      assign u_hidx = u_bidx ^ IDX_W'(ghr_q);
      // Newest outcome enters at bit 0; the oldest falls off the top.
      assign ghr_d  = GW'({ghr_q, upd_taken});
    end else begin : g_bimodal
      assign f_hidx = f_bidx;
      assign u_hidx = u_bidx;
      assign ghr_d  = ghr_q;
    end
  endgenerate

  bp_btb #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) u_btb (
    .clk      (clk),
    .rst      (rst),
    .rd_idx_i (f_bidx),
    .rd_o     (rd),
    .we_i     (upd_valid && upd_taken),
    .wr_idx_i (u_bidx),
    .wr_i     (wr)
  );

  // BTB write record: only taken outcomes allocate.
  always_comb begin
    wr       = '0;
    wr.valid = 1'b1;
    wr.jmp   = !upd_is_br;
    wr.tag   = BP_TAG_MAX'(u_tag);
    wr.tgt   = upd_target;
  end

  // Direction counters train only on conditional branches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) bht_q[i] <= CTR_RST;
    end else if (upd_valid && upd_is_br) begin
      bht_q[u_hidx] <= CTR_W'(bp_ctr_next(4'(bht_q[u_hidx]), upd_taken, CTR_W));
    end
  end

  // Non-speculative global history; jumps do not shift it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          ghr_q <= '0;
    else if (upd_valid && upd_is_br)   ghr_q <= ghr_d;
  end

  // Saturating resolved / mispredict counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_br_q  <= '0;
      cnt_mis_q <= '0;
    end else if (upd_valid) begin
      if (cnt_br_q != '1)                 cnt_br_q  <= cnt_br_q + 32'd1;
      if (upd_mispred && cnt_mis_q != '1) cnt_mis_q <= cnt_mis_q + 32'd1;
    end
  end

  assign pred_hit    = rd.valid && (rd.tag == BP_TAG_MAX'(f_tag));
  assign pred_taken  = pred_hit && (rd.jmp || bht_q[f_hidx][CTR_W-1]);
  assign pred_target = pred_hit ? rd.tgt : 32'd0;
  assign cnt_br      = cnt_br_q;
  assign cnt_mispred = cnt_mis_q;

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised dynamic branch predictor for the 5-stage RV32I pipeline.
- Replaces the static not-taken policy, where flush is driven only by a resolved taken branch.
- Sits beside the PC register. IF looks up the fetch PC combinationally to pick the next PC. EX resolution trains the tables one cycle later.
- Modes: bimodal (GHR_W=0) or gshare (GHR_W>0). Includes a tagged BTB and saturating performance counters.

Parameters:
- ENTRIES, 64: BHT and BTB depth. Must be a power of two, at least 4. IDX_W = log2(ENTRIES).
- CTR_W, 2: saturating counter width, 1..4.
- GHR_W, 0: global history length. 0 selects bimodal; otherwise gshare. Must be at most IDX_W.
- TAG_W, 10: BTB tag width. IDX_W+2+TAG_W must be at most 32.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- fetch_pc  in  32  PC currently in IF.
- pred_hit  out  1  BTB valid and tag match for fetch_pc.
- pred_taken  out  1  predict redirect.
- pred_target  out  32  predicted target; meaningful when pred_taken=1.
- upd_valid  in  1  EX resolved a control-flow instruction this cycle. Must be qualified with the pipeline not stalled.
- upd_pc  in  32  PC of the resolved instruction.
- upd_is_br  in  1  1 = conditional branch, 0 = jal/jalr.
- upd_taken  in  1  actual outcome; forced to 1 for jumps.
- upd_target  in  32  actual target address.
- upd_mispred  in  1  prediction was wrong; EX flushes.
- cnt_br  out  32  resolved control-flow count, saturating.
- cnt_mispred  out  32  mispredict count, saturating.

Behaviour:
- Reset (rst=0, asynchronous):
  - All BHT counters go to weakly-not-taken, 2^(CTR_W-1)-1 (1 for CTR_W=2).
  - All BTB valid bits, GHR, cnt_br and cnt_mispred go to 0.
  - Outputs: pred_hit=0, pred_taken=0, pred_target=0.
- Lookup is purely combinational from fetch_pc and current state (zero latency):
  - bidx = fetch_pc[IDX_W+1:2]; tag = fetch_pc[IDX_W+1+TAG_W:IDX_W+2].
  - hidx = bidx when GHR_W=0; otherwise bidx XOR {zeros, GHR}.
  - pred_hit = btb_valid[bidx] && btb_tag[bidx]==tag.
  - pred_taken = pred_hit && (btb_jmp[bidx] || bht[hidx][CTR_W-1]).
  - pred_target = pred_hit ? btb_tgt[bidx] : 0.
- Update is registered on the rising clk while upd_valid=1. Indices are computed from upd_pc and the GHR value before this edge.
  - BHT, only when upd_is_br: upd_taken increments, saturating at 2^CTR_W-1; otherwise decrements, saturating at 0.
  - BTB, only when upd_taken: write valid=1, tag, target and jmp=!upd_is_br. This overwrites any aliased entry.
  - BTB, when not taken: entry unchanged.
  - GHR, when GHR_W>0 and upd_is_br: GHR <= {GHR[GHR_W-2:0], upd_taken}. Jumps do not shift it. GHR is non-speculative.
  - Counters: cnt_br +1; cnt_mispred +1 if upd_mispred. Both hold at 32'hFFFF_FFFF.
- A lookup and an update to the same index in the same cycle returns the pre-update value. There is no bypass; the new value is visible the next cycle.
- upd_valid=0 changes no state.
- Reset asserted mid-operation wipes all state immediately, independent of clk.
- fetch_pc[1:0] and upd_pc[1:0] are ignored.
- The block has no stall input. Stall gating belongs to the caller through upd_valid.

Decomposition:
- Shared package (rv32i_types), containing:
  - bp_btb_entry_t struct {valid, jmp, tag, tgt}.
  - Function bp_ctr_next(ctr, taken) for saturating update.
  - Constant localparam for CTR_INIT.
- One sub-module, bp_btb: ENTRIES x bp_btb_entry_t flop array with async clear, one combinational read port and one synchronous write port.
- The BHT, GHR and counters stay in the top module.

Test Plan:
- Reset, then fetch_pc=0x100 -> pred_hit=0, pred_taken=0, pred_target=0, cnt_br=0.
- Bimodal default: one update {pc=0x100, is_br=1, taken=1, tgt=0x200} -> next cycle pred_hit=1, ctr 1->2, pred_taken=1, pred_target=0x200, cnt_br=1.
- Saturation: 5 taken updates then 1 not-taken at 0x100 -> ctr 3->2, pred_taken still 1. A second not-taken -> pred_taken=0 with pred_hit=1.
- Alias: train 0x100; lookup 0x100+ENTRIES*4 (0x200) -> pred_hit=0. jal update {pc=0x200, is_br=0, tgt=0x40} -> 0x100 misses; 0x200 gives pred_taken=1 and target 0x40.
- Gshare (GHR_W=4): branch at 0x80 updated with alternating outcomes T,N,T,N for 8 updates -> GHR pattern alternates 0101/1010 and steady-state prediction matches the next outcome. A jal update leaves GHR unchanged.
- Same-cycle update and lookup at 0x100 (ctr=1) -> pred_taken=0 that cycle, 1 the next.
- Assert rst mid-training with no clock edge -> all outputs 0 immediately.
- upd_mispred pulse 3 times -> cnt_mispred=3.
- Preload cnt_br near max via force -> holds at 32'hFFFF_FFFF.
